aes_inv_keygen: RTL and testbench

- Sequential round-key source for the AES-128 decryption datapath.
- Accepts the 128-bit cipher key (round-0 key) and expands it forward one round per clock to the round-10 key.
- Then emits round keys in reverse order (10 down to 0) over a valid/ready handshake, one key per accepted transfer.
- Reverse keys are derived with the inverse key-schedule recurrence, so no 11-entry key store is required.

---
 rtl/aes_keygen_pkg.sv | 67 ++++++
 rtl/aes_subword.sv | 35 +++
 rtl/aes_inv_keygen.sv | 133 +++++++++++++
 tb/tb_aes_inv_keygen.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_keygen_pkg.sv
// Shared types, constants and round functions for the AES-128 inverse
// round-key generator: state encoding, word/key types, Rcon table and the
// forward/inverse key-schedule recurrences. The S-box itself lives in
// aes_subword so a single instance can be shared between both directions.
package aes_keygen_pkg;

    localparam int AES_NR = 10;
    localparam int AES_KW = 128;

    typedef logic [31:0]       word_t;
    typedef logic [0:AES_KW-1] key_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_REV,
        ST_DONE
    } state_e;

    // Round constant for round r (1..10) in the top byte; zero elsewhere.
    function automatic word_t rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h000000};
    endfunction

    // Cyclic left rotation by one byte.
    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // One forward key-schedule step. sub_rot = SubWord(RotWord(w3)).
    function automatic key_t fwd_round(input key_t k, input word_t sub_rot,
                                       input logic [3:0] r);
        word_t n0, n1, n2, n3;
        n0 = k[0:31]   ^ sub_rot ^ rcon(r);
        n1 = k[32:63]  ^ n0;
        n2 = k[64:95]  ^ n1;
        n3 = k[96:127] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // One inverse key-schedule step from round r to round r-1.
    // sub_rot = SubWord(RotWord(w3 ^ w2)), i.e. of the recovered w3.
    function automatic key_t inv_round(input key_t k, input word_t sub_rot,
                                       input logic [3:0] r);
        word_t n0, n1, n2, n3;
        n3 = k[96:127] ^ k[64:95];
        n2 = k[64:95]  ^ k[32:63];
        n1 = k[32:63]  ^ k[0:31];
        n0 = k[0:31]   ^ sub_rot ^ rcon(r);
        return {n0, n1, n2, n3};
    endfunction

endpackage

// File: rtl/aes_subword.sv
// AES SubWord: four parallel S-box lookups on a 32-bit word.
module aes_subword (
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    // Forward S-box, entry 0x00 in the leftmost byte.
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign word_out[8*i +: 8] = sbox_lookup(word_in[8*i +: 8]);
    end

endmodule

// File: rtl/aes_inv_keygen.sv
// AES-128 decryption round-key source. Expands the cipher key forward to
// round 10, then walks the inverse key schedule back to round 0, handing
// out one round key per accepted valid/ready transfer.
// Optional build macro AES_INV_KEYGEN_LAST_LOAD_EN adds key_is_last, which
// loads key_in as the round-10 key and skips the forward expansion.
module aes_inv_keygen
    import aes_keygen_pkg::*;
#(
    parameter int NR = AES_NR,
    parameter int KW = AES_KW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [0:KW-1] key_in,
`ifdef AES_INV_KEYGEN_LAST_LOAD_EN
    input  logic          key_is_last,
`endif
    output logic          busy,
    output logic          rk_valid,
    input  logic          rk_ready,
    output logic [0:KW-1] rk_data,
    output logic [0:3]    rk_round,
    output logic          done
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    state_e     state_q, state_d;
    logic [3:0] rnd_q,   rnd_d;
    key_t       key_q,   key_d;

    word_t      sub_in;
    word_t      sub_out;

    // Shared S-box: forward uses w3, reverse uses the recovered w3 = w3^w2.
    assign sub_in = (state_q == ST_REV) ? rot_word(key_q[96:127] ^ key_q[64:95])
                                        : rot_word(key_q[96:127]);

    aes_subword u_subword (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    // Next-state, round counter and key register update.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        rnd_d   = rnd_q;
        key_d   = key_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    rnd_d   = 4'd0;
                    state_d = ST_FWD;
`ifdef AES_INV_KEYGEN_LAST_LOAD_EN
                    if (key_is_last) begin
                        rnd_d   = LAST_RND;
                        state_d = ST_REV;
                    end
`endif
                end
            end
            ST_FWD: begin
                key_d = fwd_round(key_q, sub_out, rnd_q + 4'd1);
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == LAST_RND - 4'd1) begin
                    state_d = ST_REV;
                end
            end
            ST_REV: begin
                if (rk_ready) begin
                    if (rnd_q == 4'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        key_d = inv_round(key_q, sub_out, rnd_q);
                        rnd_d = rnd_q - 4'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, round and key registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the key register is a plain register, not a memory, so it is reset to keep outputs defined.
            state_q <= ST_IDLE;
            rnd_q   <= 4'd0;
            key_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            state_q <= state_d;
            rnd_q   <= rnd_d;
            key_q   <= key_d;
        end
    end

    // Outputs decoded from state; data is forced to zero outside REV.
    always_comb begin
        busy     = 1'b0;
        rk_valid = 1'b0;
        rk_data  = '0;
        rk_round = 4'd0;
        done     = 1'b0;
        case (state_q)
            ST_FWD: begin
                busy = 1'b1;
            end
            ST_REV: begin
                busy     = 1'b1;
                rk_valid = 1'b1;
                rk_data  = key_q;
                rk_round = rnd_q;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_inv_keygen.sv
// Self-checking bench for aes_inv_keygen. Expected round keys come from
// FIPS-197 constants and are queued when a run is started; the consumer
// pops and compares them as the DUT hands each key out.
module tb_aes_inv_keygen;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [0:127] key_in;
`ifdef AES_INV_KEYGEN_LAST_LOAD_EN
    logic         key_is_last;
`endif
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [0:127] rk_data;
    logic [0:3]   rk_round;
    logic         done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]   rnd;
        logic [0:127] data;
        bit           chk;
    } exp_t;

    exp_t sb_q[$];

    localparam logic [0:127] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes_inv_keygen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .key_in      (key_in),
`ifdef AES_INV_KEYGEN_LAST_LOAD_EN
        .key_is_last (key_is_last),
`endif
        .busy        (busy),
        .rk_valid    (rk_valid),
        .rk_ready    (rk_ready),
        .rk_data     (rk_data),
        .rk_round    (rk_round),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIPS-197 Appendix A.1 round keys for 2b7e1516...
    function automatic logic [0:127] fips_rk(input int r);
        case (r)
            0:       return 128'h2b7e151628aed2a6abf7158809cf4f3c;
            1:       return 128'ha0fafe1788542cb123a339392a6c7605;
            2:       return 128'hf2c295f27a96b9435935807a7359f67f;
            3:       return 128'h3d80477d4716fe3e1e237e446d7a883b;
            4:       return 128'hef44a541a8525b7fb671253bdb0bad00;
            5:       return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
            6:       return 128'h6d88a37a110b3efddbf98641ca0093fd;
            7:       return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
            8:       return 128'head27321b58dbad2312bf5607f8d292f;
            9:       return 128'hac7766f319fadc2128d12941575c006e;
            default: return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        endcase
    endfunction

    task automatic push_fips();
        exp_t e;
        for (int r = 10; r >= 0; r--) begin
            e.rnd  = 4'(r);
            e.data = fips_rk(r);
            e.chk  = 1'b1;
            sb_q.push_back(e);
        end
    endtask

    task automatic push_zero();
        exp_t e;
        for (int r = 10; r >= 0; r--) begin
            e.rnd = 4'(r);
            e.chk = (r == 10) || (r == 1) || (r == 0);
            case (r)
                10:      e.data = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
                1:       e.data = 128'h62636363626363636263636362636363;
                default: e.data = '0;
            endcase
            sb_q.push_back(e);
        end
    endtask

    // Starts a run with key and consumes keys until done (or abort_round is
    // seen valid). rand_ready stalls the consumer randomly; hammer_start
    // keeps toggling start (and key_in) while the run is in progress.
    task automatic run_seq(input logic [0:127] key, input bit rand_ready,
                           input bit hammer_start, input int abort_round,
                           input int exp_latency, input string tag);
        int           edges;
        int           xfers;
        bit           seen_valid;
        bit           stalled;
        bit           finished;
        bit           aborted;
        bit           rdy;
        logic [0:127] held_d;
        logic [0:3]   held_r;
        exp_t         e;

        @(negedge clk);
        start      = 1'b1;
        key_in     = key;
        rk_ready   = 1'b0;
        edges      = 0;
        xfers      = 0;
        seen_valid = 1'b0;
        stalled    = 1'b0;
        finished   = 1'b0;
        aborted    = 1'b0;

        while (!finished && edges < 300) begin
            @(negedge clk);
            edges++;
            key_in = {$urandom, $urandom, $urandom, $urandom};

            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL %s busy edge=%0d got=%b want=1", tag, edges, busy);
            end

            if (rk_valid === 1'b1 && !seen_valid) begin
                seen_valid = 1'b1;
                checks++;
                if (edges !== exp_latency) begin
                    failures++;
                    $display("FAIL %s latency got=%0d want=%0d", tag, edges, exp_latency);
                end
            end

            if (stalled) begin
                checks++;
                if (rk_valid !== 1'b1 || rk_data !== held_d || rk_round !== held_r) begin
                    failures++;
                    $display("FAIL %s stall_hold valid=%b round=%0d data=%h want round=%0d data=%h",
                             tag, rk_valid, rk_round, rk_data, held_r, held_d);
                end
            end

            if (abort_round >= 0 && rk_valid === 1'b1 && int'(rk_round) == abort_round) begin
                aborted = 1'b1;
                break;
            end

            if (done === 1'b1) begin
                finished = 1'b1;
                checks++;
                if (rk_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL %s valid_in_done got=%b want=0", tag, rk_valid);
                end
            end

            start = (hammer_start && !finished) ? 1'($urandom_range(0, 1)) : 1'b0;

            rdy      = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            rk_ready = rdy;
            stalled  = (rk_valid === 1'b1) && !rdy;
            held_d   = rk_data;
            held_r   = rk_round;

            if (rk_valid === 1'b1 && rdy) begin
                xfers++;
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s extra_key round=%0d data=%h want none", tag, rk_round, rk_data);
                end else begin
                    e = sb_q.pop_front();
                    if (rk_round !== e.rnd) begin
                        failures++;
                        $display("FAIL %s round got=%0d want=%0d", tag, rk_round, e.rnd);
                    end
                    if (e.chk) begin
                        checks++;
                        if (rk_data !== e.data) begin
                            failures++;
                            $display("FAIL %s key_r%0d got=%h want=%h", tag, e.rnd, rk_data, e.data);
                        end
                    end
                end
            end
        end

        start    = 1'b0;
        rk_ready = 1'b0;
        if (aborted) return;

        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL %s timeout done not seen within %0d cycles", tag, edges);
        end
        checks++;
        if (xfers !== 11) begin
            failures++;
            $display("FAIL %s transfers got=%0d want=11", tag, xfers);
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s leftover_keys got=%0d want=0", tag, sb_q.size());
        end
        sb_q.delete();

        // done is a single pulse and no second run follows.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || rk_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s after_done cyc=%0d done=%b busy=%b valid=%b want 0,0,0",
                         tag, i, done, busy, rk_valid);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0 ||
            rk_data !== 128'h0 || rk_round !== 4'd0) begin
            failures++;
            $display("FAIL reset_outputs busy=%b valid=%b done=%b round=%0d data=%h want all 0",
                     busy, rk_valid, done, rk_round, rk_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rk_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b valid=%b want 0,0", busy, rk_valid);
        end
    endtask

    task automatic test_fips_continuous();
        push_fips();
        run_seq(FIPS_KEY, 1'b0, 1'b0, -1, 11, "fips_cont");
    endtask

    task automatic test_random_stall();
        push_fips();
        run_seq(FIPS_KEY, 1'b1, 1'b0, -1, 11, "fips_stall");
    endtask

    task automatic test_start_ignored();
        push_fips();
        run_seq(FIPS_KEY, 1'b1, 1'b1, -1, 11, "start_ignored");
    endtask

    task automatic test_reset_mid();
        push_fips();
        run_seq(FIPS_KEY, 1'b0, 1'b0, 5, 11, "reset_mid");
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0 ||
            rk_data !== 128'h0 || rk_round !== 4'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs busy=%b valid=%b done=%b round=%0d data=%h want all 0",
                     busy, rk_valid, done, rk_round, rk_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_idle done=%b busy=%b want 0,0", done, busy);
            end
        end
        push_fips();
        run_seq(FIPS_KEY, 1'b0, 1'b0, -1, 11, "after_reset");
    endtask

    task automatic test_zero_key();
        push_zero();
        run_seq(128'h0, 1'b0, 1'b0, -1, 11, "zero_key");
    endtask

`ifdef AES_INV_KEYGEN_LAST_LOAD_EN
    task automatic test_last_load();
        key_is_last = 1'b1;
        push_fips();
        run_seq(FIPS_R10, 1'b0, 1'b0, -1, 1, "last_load");
        key_is_last = 1'b0;
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        key_in   = '0;
        rk_ready = 1'b0;
`ifdef AES_INV_KEYGEN_LAST_LOAD_EN
        key_is_last = 1'b0;
`endif
        #1;
        test_reset();
        test_fips_continuous();
        test_random_stall();
        test_start_ignored();
        test_reset_mid();
        test_zero_key();
`ifdef AES_INV_KEYGEN_LAST_LOAD_EN
        test_last_load();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
